conv3x3_stream_engine: RTL and testbench

//  Parametrised successor to the fixed 4-wide 3x3 conv controller.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/linebuffer_3x3_param.sv | 35 +++
 rtl/conv3x3_stream_engine.sv | 167 ++++++++++++++++
 tb/tb_conv3x3_stream_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution engine.
// Sums are widened to 64 bits inside sat_shift, which assumes DW <= 28.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int STRIDE_MAX = 2;

  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] sum,
                                                   input int unsigned shift,
                                                   input int dw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = sum >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/linebuffer_3x3_param.sv
// Two row delay lines plus a 3x3 shift window; updates only when en is high.
// Rows are addressed by the column index, so their effective length is the runtime image width.
module linebuffer_3x3_param #(
  parameter int DW    = 16,
  parameter int MAX_W = 64,
  parameter int AW    = $clog2(MAX_W)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        din,
  output logic [8:0][DW-1:0]   win
);

  logic [DW-1:0] row_mid [MAX_W];
  logic [DW-1:0] row_top [MAX_W];

  // win[r*3+c]: r=0 is the oldest row, c=2 is the newest column.
  always_ff @(posedge clk) begin
    if (en) begin
      row_top[addr] <= row_mid[addr];
      row_mid[addr] <= din;
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= row_top[addr];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= row_mid[addr];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= din;
    end
  end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streams a raster ifmap into 3x3 windows (stride 1/2) and emits saturated MAC results, 3-cycle latency.
// A held, unaccepted output freezes the whole pipeline and the line buffer; in_ready drops with it.
module conv3x3_stream_engine
  import conv_pkg::*;
#(
  parameter int DW    = 16,
  parameter int MAX_W = 64,
  parameter int CW    = 16,
  parameter int SHW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     cfg_w,
  input  logic [CW-1:0]     cfg_h,
  input  logic [1:0]        cfg_stride,
  input  logic [SHW-1:0]    cfg_shift,
  input  logic [9*DW-1:0]   weight,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int AW = $clog2(MAX_W);
  localparam int SW = 2*DW + 4;

  state_t              state;
  logic [CW-1:0]       w_r, h_r, row, col;
  logic                s2_r;
  logic [SHW-1:0]      shift_r;
  logic [2*CW-1:0]     out_total, out_cnt;
  logic                outs_done;

  logic                adv, accept, out_acc, last_pix, last_out, win_hit, cfg_ok;
  logic [CW-1:0]       ow_n, oh_n;

  logic [8:0][DW-1:0]  win;
  logic                s0_vld, s1_vld;
  logic signed [2*DW-1:0] prod [9];
  logic signed [SW-1:0]   sum;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = (state == RUN) && adv;
  assign accept   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;
  assign busy     = (state != IDLE);
  assign last_pix = (row == h_r - CW'(1)) && (col == w_r - CW'(1));
  assign last_out = out_acc && (out_cnt == out_total - (2*CW)'(1));
  assign win_hit  = (row >= CW'(2)) && (col >= CW'(2)) && (!s2_r || (!row[0] && !col[0]));

  assign cfg_ok = (cfg_w >= CW'(3)) && (cfg_w <= CW'(MAX_W)) && (cfg_h >= CW'(3)) &&
                  ((cfg_stride == 2'd1) || (cfg_stride == 2'(STRIDE_MAX)));
  assign ow_n   = ((cfg_w - CW'(3)) >> (cfg_stride == 2'd2)) + CW'(1);
  assign oh_n   = ((cfg_h - CW'(3)) >> (cfg_stride == 2'd2)) + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      w_r       <= '0;
      h_r       <= '0;
      s2_r      <= 1'b0;
      shift_r   <= '0;
      row       <= '0;
      col       <= '0;
      out_total <= '0;
      out_cnt   <= '0;
      outs_done <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (out_acc) out_cnt <= out_cnt + (2*CW)'(1);
      if (accept) begin
        if (col == w_r - CW'(1)) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w_r       <= cfg_w;
              h_r       <= cfg_h;
              s2_r      <= (cfg_stride == 2'd2);
              shift_r   <= cfg_shift;
              out_total <= {{CW{1'b0}}, ow_n} * {{CW{1'b0}}, oh_n};
              row       <= '0;
              col       <= '0;
              out_cnt   <= '0;
              outs_done <= 1'b0;
              state     <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          // With stride 2 the final result can leave before the trailing pixels arrive.
          if (last_out) outs_done <= 1'b1;
          if (accept && last_pix) begin
            if (outs_done || last_out) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_out) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  linebuffer_3x3_param #(.DW(DW), .MAX_W(MAX_W), .AW(AW)) u_lb (
    .clk  (clk),
    .en   (accept),
    .addr (col[AW-1:0]),
    .din  (in_data),
    .win  (win)
  );

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = 0; i < 9; i++) begin
        prod[i] <= $signed(win[i]) * $signed(weight[i*DW +: DW]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      sum = sum + SW'(prod[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_vld    <= 1'b0;
      s1_vld    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s0_vld    <= accept && win_hit;
      s1_vld    <= s0_vld;
      out_valid <= s1_vld;
      if (s1_vld) out_data <= DW'(sat_shift(64'(sum), 32'(shift_r), DW));
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Directed bench for conv3x3_stream_engine: vector table of frames plus stall, config-error and reset sequences.
module tb_conv3x3_stream_engine;

  localparam int DW = 16, MAX_W = 64, CW = 16, SHW = 5;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [CW-1:0]     cfg_w, cfg_h;
  logic [1:0]        cfg_stride;
  logic [SHW-1:0]    cfg_shift;
  logic [9*DW-1:0]   weight;
  logic [DW-1:0]     in_data, out_data;
  logic              in_valid, in_ready, out_valid, out_ready, busy, done, cfg_err;

  always #5 clk = ~clk;

  conv3x3_stream_engine #(.DW(DW), .MAX_W(MAX_W), .CW(CW), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_stride(cfg_stride), .cfg_shift(cfg_shift), .weight(weight),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    int w; int h; int stride; int shift;
    logic [DW-1:0] pbase; logic [DW-1:0] pstep; logic [DW-1:0] wt;
    int n_exp;
    logic [3:0][DW-1:0] exp;
  } vec_t;

  vec_t vecs [9];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(int w, int h, int s, int sh, logic [DW-1:0] pb, logic [DW-1:0] ps,
                              logic [DW-1:0] wt, int n, logic [DW-1:0] e0, logic [DW-1:0] e1,
                              logic [DW-1:0] e2, logic [DW-1:0] e3);
    vec_t v;
    v.w = w; v.h = h; v.stride = s; v.shift = sh;
    v.pbase = pb; v.pstep = ps; v.wt = wt; v.n_exp = n;
    v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic run_frame(input vec_t v, input int stall, input bit mid_start);
    int idx = 0, n_out = 0, cyc = 0, stall_left = 0;
    int first_cyc = -1, win_acc_cyc = -1, last_out_cyc = -1, last_pix_cyc = -1, done_cyc = -1;
    int npix = v.w * v.h;
    int exp_done;
    bit stalled = 0;
    cfg_w = CW'(v.w); cfg_h = CW'(v.h); cfg_stride = 2'(v.stride); cfg_shift = SHW'(v.shift);
    weight = {9{v.wt}};
    start = 1'b1;
    #1 check("start_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    while (done_cyc < 0 && cyc < 400) begin
      in_valid  = (idx < npix);
      in_data   = v.pbase + DW'(idx) * v.pstep;
      out_ready = 1'b1;
      if (mid_start) begin
        start = (cyc == 5);
        if (cyc >= 5) begin
          cfg_w = 7; cfg_h = 9; cfg_stride = 2; cfg_shift = 3;
        end
      end
      #1;
      if (stall > 0 && !stalled && out_valid) begin
        stalled = 1;
        stall_left = stall;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        #1;
        check("stall_data", out_data, v.exp[0]);
        check("stall_in_ready", in_ready, 0);
        stall_left--;
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (in_valid && in_ready) begin
        if (idx == 2*v.w + 2) win_acc_cyc = cyc;
        if (idx == npix - 1) last_pix_cyc = cyc;
        idx++;
      end
      if (out_valid && out_ready) begin
        if (n_out < v.n_exp) check("out_data", out_data, v.exp[n_out]);
        n_out++;
        last_out_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      cyc++;
      if (done_cyc < 0) @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    exp_done = ((last_out_cyc > last_pix_cyc) ? last_out_cyc : last_pix_cyc) + 1;
    check("frame_finished", done_cyc >= 0, 1);
    check("out_count", n_out, v.n_exp);
    check("pixels_taken", idx, npix);
    check("latency", first_cyc - win_acc_cyc, 3);
    check("done_cycle", done_cyc, exp_done);
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  task automatic err_start(input int w, input int h, input int s);
    cfg_w = CW'(w); cfg_h = CW'(h); cfg_stride = 2'(s); cfg_shift = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    @(negedge clk);
    #1;
    check("cfg_err_clear", cfg_err, 0);
    check("cfg_err_busy2", busy, 0);
  endtask

  initial begin
    int fed;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_w = 4; cfg_h = 4; cfg_stride = 1; cfg_shift = 0; weight = '0;

    vecs[0] = mk(4, 4, 1, 0, 1, 1, 1, 4, 54, 63, 90, 99);
    vecs[1] = mk(5, 5, 2, 0, 1, 1, 1, 4, 63, 81, 153, 171);
    vecs[2] = mk(3, 3, 1, 0, 16'h7FFF, 0, 16'h7FFF, 1, 16'h7FFF, 0, 0, 0);
    vecs[3] = mk(3, 3, 1, 0, 16'h8000, 0, 16'h7FFF, 1, 16'h8000, 0, 0, 0);
    vecs[4] = mk(4, 4, 1, 2, 1, 1, 1, 4, 13, 15, 22, 24);
    vecs[5] = mk(4, 4, 1, 0, 1, 1, 16'hFFFF, 4, 16'hFFCA, 16'hFFC1, 16'hFFA6, 16'hFF9D);
    vecs[6] = mk(4, 4, 1, 3, 1, 1, 16'hFFFF, 4, 16'hFFF9, 16'hFFF8, 16'hFFF4, 16'hFFF3);
    vecs[7] = mk(4, 4, 2, 0, 1, 1, 1, 1, 54, 0, 0, 0);
    vecs[8] = mk(3, 5, 1, 0, 1, 1, 1, 3, 45, 72, 99, 0);

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Frames run back to back: each start lands in the cycle the previous done is high.
    for (int i = 0; i < 9; i++) run_frame(vecs[i], 0, 0);
    idle_check(2);

    // Held output with a mid-frame start and cfg change that must be ignored.
    run_frame(vecs[0], 5, 1);
    idle_check(2);

    err_start(2, 4, 1);
    err_start(MAX_W + 1, 4, 1);
    err_start(4, 4, 3);
    err_start(4, 2, 1);

    // Reset in the middle of a frame, then a clean frame.
    cfg_w = 4; cfg_h = 4; cfg_stride = 1; cfg_shift = 0; weight = {9{16'd1}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fed = 0;
    for (int c = 0; c < 50 && fed < 7; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(fed + 1);
      #1;
      if (in_ready) fed++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid_fed", fed, 7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(vecs[0], 0, 0);
    idle_check(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
